// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states and the
// divide-by-zero result used when ALU_CHECK_EN is defined.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_DIV  = 3'd3,
        OP_MOD  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_GT   = 3'd7
    } alu_op_e;

    localparam logic [4:0] DIV0_RESULT = 5'h1F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } seq_state_e;

    function automatic logic is_div_op(input logic [2:0] sel);
        return (sel == OP_DIV) || (sel == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap modulo DEPTH (power of 2).
// Push is ignored when full, pop is ignored when empty.
module alu_cmd_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, drives them to the ALU one at a time and returns results.
// Define ALU_CHECK_EN to substitute DIV0_RESULT and flag rsp_err on div/mod by zero.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W        = 4,
    parameter int SEL_W         = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [SEL_W-1:0]  cmd_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W:0]   alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W:0]   rsp_data,
    output logic [SEL_W-1:0]  rsp_sel,
    output logic              rsp_err
);

    localparam int CMD_W = 2 * DATA_W + SEL_W;
    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W:0]   rsp_data_q, rsp_data_d;
    logic [SEL_W-1:0]  rsp_sel_q, rsp_sel_d;
    logic              rsp_err_q, rsp_err_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [FC_W-1:0]   fifo_count;
    logic [CMD_W-1:0]  fifo_rdata;
    logic              load;

    assign cmd_ready = (fifo_count != FC_W'(FIFO_DEPTH));
    assign fifo_push = cmd_valid && cmd_ready && !reset;

    alu_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({cmd_a, cmd_b, cmd_sel}),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_sel_d   = rsp_sel_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_data_d  = alu_out;
                    rsp_sel_d   = alu_sel_q;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef ALU_CHECK_EN
                    if (is_div_op(3'(alu_sel_q)) && alu_b_q == '0) begin
                        rsp_data_d = (DATA_W + 1)'(DIV0_RESULT);
                        rsp_err_d  = 1'b1;
                    end
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) load = 1'b1;
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared by IDLE and the back-to-back path out of RESP
        if (load) begin
            fifo_pop = 1'b1;
            {alu_a_d, alu_b_d, alu_sel_d} = fifo_rdata;
            cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
            state_d  = SETTLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_sel_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_sel   = rsp_sel_q;
    assign rsp_err   = rsp_err_q;

endmodule
